// File: rtl/dec_clk_monitor_if.sv
// rtl/dec_clk_monitor_if.sv - measurement output handshake bundle for dec_clk_monitor
//
// Signals:
//   meas_period : captured dec_clk period in clk cycles
//   meas_high   : captured dec_clk high time in clk cycles
//   meas_ovf    : captured period saturated (dec_clk stopped)
//   meas_valid  : measurement available
//   meas_ready  : consumer accepts the measurement
// Modports: master = monitor side, slave = consumer side.

interface dec_clk_monitor_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             meas_ovf;
    logic             meas_valid;
    logic             meas_ready;

    modport master (
        output meas_period,
        output meas_high,
        output meas_ovf,
        output meas_valid,
        input  meas_ready
    );

    modport slave (
        input  meas_period,
        input  meas_high,
        input  meas_ovf,
        input  meas_valid,
        output meas_ready
    );
endinterface

// File: rtl/dec_clk_monitor.sv
// rtl/dec_clk_monitor.sv - measures dec_clk period/high time and reports lock/error status
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   dec_clk_in      : divided clock under test (asynchronous to clk)
//   expected_ratio  : ratio programmed into the divider
//   stat_clr        : pulse clearing err_sticky and overrun_sticky
//   meas            : measurement output register with valid/ready handshake
//   locked          : period matched expected_ratio LOCK_COUNT times in a row
//   err_sticky      : period mismatch seen while compare enabled
//   overrun_sticky  : unaccepted measurement was overwritten

module dec_clk_monitor #(
    parameter int CNT_W      = 8,
    parameter int RATIO_W    = 7,
    parameter int LOCK_COUNT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_clk_in,
    input  logic [RATIO_W-1:0]  expected_ratio,
    input  logic                stat_clr,
    dec_clk_monitor_if.master   meas,
    output logic                locked,
    output logic                err_sticky,
    output logic                overrun_sticky
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_COUNT);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t           state_q, state_d;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             cap_now, cap_ovf_now;

    // capture stage between the counters and the output register
    logic             cap_q;
    logic [CNT_W-1:0] cap_period_q, cap_high_q;
    logic             cap_ovf_q;

    logic [RATIO_W-1:0] ratio_q;
    logic               ratio_seen;
    logic               ratio_chg;
    logic               discard;
    logic [3:0]         match_cnt;
    logic               cmp_en;
    logic               is_match;
    logic               err_set;
    logic               ovr_set;

    assign rise = s2 & ~s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= dec_clk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            high_q   <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            high_q   <= high_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        high_d      = high_q;
        cap_now     = 1'b0;
        cap_ovf_now = 1'b0;
        case (state_q)
            IDLE: begin
                period_d = '0;
                high_d   = '0;
                // first rise only arms the measurement (partial period)
                if (rise) begin
                    state_d  = MEAS;
                    period_d = CNT_W'(1);
                    high_d   = CNT_W'(1);
                end
            end
            MEAS: begin
                if (rise) begin
                    cap_now  = 1'b1;
                    period_d = CNT_W'(1);
                    high_d   = CNT_W'(1);
                end else if (period_q == CNT_MAX) begin
                    // dec_clk has stopped: report the saturated period and re-arm
                    cap_now     = 1'b1;
                    cap_ovf_now = 1'b1;
                    state_d     = IDLE;
                    period_d    = '0;
                    high_d      = '0;
                end else begin
                    period_d = period_q + CNT_W'(1);
                    if (s2) begin
                        high_d = high_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q        <= 1'b0;
            cap_period_q <= '0;
            cap_high_q   <= '0;
            cap_ovf_q    <= 1'b0;
        end else begin
            cap_q <= cap_now;
            if (cap_now) begin
                cap_period_q <= period_q;
                cap_high_q   <= high_q;
                cap_ovf_q    <= cap_ovf_now;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas.meas_period <= '0;
            meas.meas_high   <= '0;
            meas.meas_ovf    <= 1'b0;
            meas.meas_valid  <= 1'b0;
        end else if (cap_q) begin
            meas.meas_period <= cap_period_q;
            meas.meas_high   <= cap_high_q;
            meas.meas_ovf    <= cap_ovf_q;
            meas.meas_valid  <= 1'b1;
        end else if (meas.meas_valid && meas.meas_ready) begin
            meas.meas_valid <= 1'b0;
        end
    end

    // ratio_seen suppresses a spurious "change" on the first cycle after reset
    assign ratio_chg = ratio_seen && (expected_ratio != ratio_q);
    assign cmp_en    = expected_ratio > RATIO_W'(1);
    assign is_match  = !cap_ovf_q && (cap_period_q == CNT_W'(expected_ratio));
    assign err_set   = cap_q && !ratio_chg && !discard && cmp_en && !is_match;
    assign ovr_set   = cap_q && meas.meas_valid && !meas.meas_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ratio_q    <= '0;
            ratio_seen <= 1'b0;
            discard    <= 1'b0;
            match_cnt  <= '0;
            locked     <= 1'b0;
        end else begin
            ratio_q    <= expected_ratio;
            ratio_seen <= 1'b1;
            if (ratio_chg) begin
                match_cnt <= '0;
                locked    <= 1'b0;
                discard   <= 1'b1;
            end else if (cap_q) begin
                discard <= 1'b0;
                if (!cmp_en || !is_match) begin
                    match_cnt <= '0;
                    locked    <= 1'b0;
                end else if (!discard) begin
                    if (match_cnt != LOCK_TGT) begin
                        match_cnt <= match_cnt + 4'd1;
                    end
                    locked <= (match_cnt >= LOCK_TGT - 4'd1);
                end
            end else if (!cmp_en) begin
                match_cnt <= '0;
                locked    <= 1'b0;
            end
        end
    end

    // set has priority over a coincident stat_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky     <= 1'b0;
            overrun_sticky <= 1'b0;
        end else begin
            if (err_set) begin
                err_sticky <= 1'b1;
            end else if (stat_clr) begin
                err_sticky <= 1'b0;
            end
            if (ovr_set) begin
                overrun_sticky <= 1'b1;
            end else if (stat_clr) begin
                overrun_sticky <= 1'b0;
            end
        end
    end
endmodule

// File: doc/dec_clk_monitor.md
Name: dec_clk_monitor

Overview:
- Sits directly downstream of the clock divider and consumes its dec_clk output.
- Measures each dec_clk period and high time in clk cycles, compares the period against the programmed decimation ratio, and reports lock/error status.
- Each measurement is presented on a valid/ready output register for a readback or debug stage.

Parameters:
- CNT_W, 8: width of the period/high-time counters and the measurement outputs.
- RATIO_W, 7: width of expected_ratio; must match the divider's decimation_ratio width.
- LOCK_COUNT, 4: number of consecutive matching periods required to assert locked (1..15).

Ports:
- clk, input, 1: clock; all state is sampled on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- dec_clk_in, input, 1: divided clock from the divider; treated as asynchronous.
- expected_ratio, input, RATIO_W: ratio currently programmed into the divider.
- stat_clr, input, 1: single-cycle pulse that clears the sticky flags.
- meas_period, output, CNT_W: captured period in clk cycles.
- meas_high, output, CNT_W: captured high time in clk cycles.
- meas_ovf, output, 1: captured period saturated.
- meas_valid, output, 1: measurement available.
- meas_ready, input, 1: consumer accepts the measurement.
- locked, output, 1: period has matched expected_ratio for LOCK_COUNT consecutive periods.
- err_sticky, output, 1: a period mismatch occurred while compare was enabled.
- overrun_sticky, output, 1: an unaccepted measurement was overwritten.

Behaviour:
- Reset (async assert, sync release): every output is 0, state = IDLE, all counters 0, synchronizer flops 0.
- Synchronizer and edge detect:
  - dec_clk_in passes through a 2-flop synchronizer (s1, s2), then a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- FSM states: IDLE and MEAS.
  - IDLE: counters held at 0; on rise, go to MEAS with period_cnt = 1 and high_cnt = 1. The first partial period produces no measurement.
  - MEAS, no rise: period_cnt increments, saturating at 2^CNT_W-1. high_cnt increments while s2 = 1 and holds after fall.
  - MEAS, rise: capture period_cnt and high_cnt, then reload both counters to 1.
  - MEAS, saturation: when period_cnt reaches 2^CNT_W-1, capture the saturated values with ovf = 1, go to IDLE and clear locked (clock stopped). This capture uses the same output-register rules as a normal capture.
- Result:
  - A constant dec_clk of period P and high time H yields meas_period = P and meas_high = H.
  - meas_valid rises on the clk edge after the capture, i.e. 3 clk edges after the edge that first samples dec_clk_in high.
- Output handshake:
  - Transfer occurs on a cycle with meas_valid & meas_ready; meas_valid then falls on the next edge unless a new capture occurs in the same cycle.
  - A capture always loads the output register and sets meas_valid.
  - If meas_valid = 1 and meas_ready = 0 at capture, the old data is lost and overrun_sticky sets.
  - Outputs stay stable while meas_valid = 1 and no capture occurs.
- Lock logic:
  - Compare is enabled when expected_ratio >= 2.
  - On each capture with compare enabled:
    - Match (meas_ovf = 0 and period == expected_ratio, zero-extended): the match counter increments, saturating at LOCK_COUNT. locked = 1 when the counter equals LOCK_COUNT.
    - Mismatch: clear the match counter and locked; set err_sticky.
  - Compare disabled: the match counter and locked are held at 0; err_sticky is never set.
  - Any change of expected_ratio (registered comparison) clears the match counter and locked on the following edge and discards the next capture from the compare; that discarded capture does not set err_sticky.
- Sticky flags:
  - stat_clr clears err_sticky and overrun_sticky.
  - If stat_clr coincides with a new set event, the set wins.
- Reset mid-operation aborts the measurement immediately; the first post-reset rise is again treated as a partial period.

Test Plan:
- Divider-style input, period 6 (high 3, low 3), expected_ratio = 6 -> measurements 6/3 with meas_valid; locked = 1 after the 4th matching capture; err_sticky = 0.
- Locked at 6, switch input to period 7 (high 3, low 4) -> next capture 7/3; locked falls the following edge; err_sticky = 1; stat_clr pulse clears err_sticky.
- dec_clk_in held low after locking -> after 255 cycles without a rise: a capture of 255 with meas_ovf = 1; FSM returns to IDLE; locked = 0.
- meas_ready = 0 across two captures of period 5 -> second capture overwrites the first; overrun_sticky = 1; meas_valid stays 1 until meas_ready = 1 for one cycle.
- expected_ratio = 1 with input period 4 -> measurements 4/2 are still produced; locked = 0 and err_sticky = 0 throughout.
- Assert rst mid-period, release, apply period 8 -> all outputs 0 during reset; the first capture after release occurs only on the 2nd post-reset rise, value 8.
